// File: rtl/blink_pkg.sv
// Shared types for the blinker counter-stream decoder.
// Holds the FSM states, step classes and the default counter width.
package blink_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        S_INIT,
        S_SYNC,
        S_LOCK
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP,
        STEP_DOWN,
        STEP_STALL,
        STEP_ERR
    } step_t;

endpackage

// File: rtl/blink_step_classify.sv
// Classifies one (prev, cur) sample pair of the counter stream.
// Pure combinational; also flags up-wrap and down-wrap steps.
module blink_step_classify
    import blink_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] cur,
    output step_t        step,
    output logic         up_wrap,
    output logic         dn_wrap
);

    logic [W-1:0] delta;

    // Modular difference; +1 is up, all-ones is down
    assign delta = cur - prev;

    always_comb begin
        step = STEP_ERR;
        if (delta == W'(1)) begin
            step = STEP_UP;
        end else if (delta == {W{1'b1}}) begin
            step = STEP_DOWN;
        end else if (delta == '0) begin
            step = STEP_STALL;
        end
    end

    assign up_wrap = (step == STEP_UP) && (prev == {W{1'b1}});
    assign dn_wrap = (step == STEP_DOWN) && (prev == '0);

endmodule

// File: rtl/blink_decoder.sv
// Receive-side decoder for the blinker up/down counter stream.
// Infers direction, flags illegal steps, counts wraps and run length.
module blink_decoder
    import blink_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int WRAP_W = 8,
    parameter int RUN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [W-1:0]      count_i,
    input  logic              clr_i,
    output logic              dir_o,
    output logic              dir_valid_o,
    output logic              step_err_o,
    output logic              err_sticky_o,
    output logic              dir_change_o,
    output logic [WRAP_W-1:0] wrap_up_o,
    output logic [WRAP_W-1:0] wrap_dn_o,
    output logic [RUN_W-1:0]  run_len_o
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;
    localparam logic [RUN_W-1:0]  RUN_MAX  = '1;

    state_t            state_q, state_d;
    logic [W-1:0]      prev_q;
    logic              dir_q, dir_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              sticky_q, sticky_d;
    logic              chg_q, chg_d;
    logic [WRAP_W-1:0] wu_q, wu_d;
    logic [WRAP_W-1:0] wd_q, wd_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              wu_ev, wd_ev;

    step_t             step;
    logic              up_wrap, dn_wrap;
    logic              is_up;

    blink_step_classify #(
        .W (W)
    ) u_classify (
        .prev    (prev_q),
        .cur     (count_i),
        .step    (step),
        .up_wrap (up_wrap),
        .dn_wrap (dn_wrap)
    );

    assign is_up = (step == STEP_UP);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        valid_d  = valid_q;
        run_d    = run_q;
        err_d    = 1'b0;
        chg_d    = 1'b0;
        wu_ev    = 1'b0;
        wd_ev    = 1'b0;
        sticky_d = clr_i ? 1'b0 : sticky_q;
        wu_d     = clr_i ? '0 : wu_q;
        wd_d     = clr_i ? '0 : wd_q;
        unique case (state_q)
            S_INIT: begin
                state_d = S_SYNC;
            end
            S_SYNC, S_LOCK: begin
                wu_ev = up_wrap;
                wd_ev = dn_wrap;
                unique case (step)
                    STEP_UP, STEP_DOWN: begin
                        if (state_q == S_LOCK && dir_q == is_up) begin
                            run_d = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
                        end else begin
                            chg_d = (state_q == S_LOCK);
                            run_d = RUN_W'(1);
                        end
                        dir_d   = is_up;
                        valid_d = 1'b1;
                        state_d = S_LOCK;
                    end
                    STEP_STALL: begin
                        valid_d = 1'b0;
                        run_d   = '0;
                        state_d = S_SYNC;
                    end
                    default: begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        valid_d  = 1'b0;
                        run_d    = '0;
                        state_d  = S_SYNC;
                    end
                endcase
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        // A wrap coinciding with clr_i still counts, starting from zero
        if (wu_ev && wu_d != WRAP_MAX) wu_d = wu_d + 1'b1;
        if (wd_ev && wd_d != WRAP_MAX) wd_d = wd_d + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_INIT;
            prev_q   <= '0;
            dir_q    <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            chg_q    <= 1'b0;
            wu_q     <= '0;
            wd_q     <= '0;
            run_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= count_i;
            dir_q    <= dir_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            chg_q    <= chg_d;
            wu_q     <= wu_d;
            wd_q     <= wd_d;
            run_q    <= run_d;
        end
    end

    assign dir_o        = dir_q;
    assign dir_valid_o  = valid_q;
    assign step_err_o   = err_q;
    assign err_sticky_o = sticky_q;
    assign dir_change_o = chg_q;
    assign wrap_up_o    = wu_q;
    assign wrap_dn_o    = wd_q;
    assign run_len_o    = run_q;

endmodule
